// File: rtl/mem_latency_shaper.sv
// Fixed-latency, outstanding-limited request shaper in front of a single-cycle
// backing memory. Requests are granted when a slot is free. They are forwarded
// to the backing port in the grant cycle. Each response is returned exactly
// LATENCY cycles after its grant, in grant order.
module mem_latency_shaper #(
   parameter int AddrWidth       = 64,
   parameter int DataWidth       = 512,
   parameter int LATENCY         = 4,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   mem_req_i,
   output logic                   mem_gnt_o,
   input  logic [AddrWidth-1:0]   mem_addr_i,
   input  logic [DataWidth-1:0]   mem_wdata_i,
   input  logic [DataWidth/8-1:0] mem_strb_i,
   input  logic                   mem_we_i,
   output logic                   mem_rvalid_o,
   output logic [DataWidth-1:0]   mem_rdata_o,
   output logic                   bm_req_o,
   output logic                   bm_we_o,
   output logic [AddrWidth-1:0]   bm_addr_o,
   output logic [DataWidth-1:0]   bm_wdata_o,
   output logic [DataWidth/8-1:0] bm_strb_o,
   input  logic [DataWidth-1:0]   bm_rdata_i,
   output logic [31:0]            rd_count_o,
   output logic [31:0]            wr_count_o
);

   localparam int CntWidth = $clog2(MAX_OUTSTANDING + 1);

   if (LATENCY < 1 || LATENCY > 64) begin : g_bad_latency
      $error("mem_latency_shaper: LATENCY must be in 1..64");
   end
   if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 64) begin : g_bad_outstanding
      $error("mem_latency_shaper: MAX_OUTSTANDING must be in 1..64");
   end

   logic [CntWidth-1:0]  r_cnt;
   logic [LATENCY:1]     r_vld;
   logic                 r_we1;
   logic [31:0]          r_rd_cnt;
   logic [31:0]          r_wr_cnt;
   logic                 w_gnt;
   logic                 w_rsp;
   logic [DataWidth-1:0] w_rsp_data;

   // A response retiring this cycle frees its slot for a same-cycle grant.
   assign w_rsp = r_vld[LATENCY] & ~rst_i;
   assign w_gnt = mem_req_i & ~rst_i &
                  ((r_cnt < CntWidth'(MAX_OUTSTANDING)) | w_rsp);

   assign mem_gnt_o    = w_gnt;
   assign mem_rvalid_o = w_rsp;
   assign mem_rdata_o  = w_rsp ? w_rsp_data : '0;

   assign bm_req_o   = w_gnt;
   assign bm_we_o    = w_gnt & mem_we_i;
   assign bm_addr_o  = w_gnt ? mem_addr_i  : '0;
   assign bm_wdata_o = w_gnt ? mem_wdata_i : '0;
   assign bm_strb_o  = w_gnt ? mem_strb_i  : '0;

   assign rd_count_o = r_rd_cnt;
   assign wr_count_o = r_wr_cnt;

   // Track granted-but-unanswered requests; grant and retire together cancel.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else if (w_gnt && !w_rsp) begin
         r_cnt <= r_cnt + CntWidth'(1);
      end else if (!w_gnt && w_rsp) begin
         r_cnt <= r_cnt - CntWidth'(1);
      end
   end

   // Valid tag pipe: stage k is set in the k-th cycle after a grant.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_vld <= '0;
         r_we1 <= 1'b0;
      end else begin
         r_vld[1] <= w_gnt;
         r_we1    <= w_gnt & mem_we_i;
         for (int k = 2; k <= LATENCY; k++) begin
            r_vld[k] <= r_vld[k-1];
         end
      end
   end

   if (LATENCY == 1) begin : g_lat1
      // Backing data arrives in the response cycle itself, so pass it straight out.
      assign w_rsp_data = r_we1 ? '0 : bm_rdata_i;
   end else begin : g_latn
      logic [DataWidth-1:0] r_dat [1:LATENCY-1];

      // Capture read data the cycle after grant (0 for writes), then delay it.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            for (int k = 1; k < LATENCY; k++) begin
               r_dat[k] <= '0;
            end
         end else begin
            r_dat[1] <= (r_vld[1] && !r_we1) ? bm_rdata_i : '0;
            for (int k = 2; k < LATENCY; k++) begin
               r_dat[k] <= r_dat[k-1];
            end
         end
      end

      assign w_rsp_data = r_dat[LATENCY-1];
   end

   // Saturating access statistics, counted at grant.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
      end else begin
         if (w_gnt && !mem_we_i && r_rd_cnt != 32'hFFFF_FFFF) begin
            r_rd_cnt <= r_rd_cnt + 32'd1;
         end
         if (w_gnt && mem_we_i && r_wr_cnt != 32'hFFFF_FFFF) begin
            r_wr_cnt <= r_wr_cnt + 32'd1;
         end
      end
   end

   // A response with nothing outstanding means the tag pipe and counter disagree.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(w_rsp && r_cnt == '0));
      end
   end

endmodule

// File: doc/mem_latency_shaper.md
# mem_latency_shaper

Fixed-latency, outstanding-limited shaper between the `axi_to_mem` memory-side port and the DPI-backed memory in the FPGA shell simulator. It grants requests from the translator and forwards them to a single-cycle backing memory port. It returns `mem_rvalid`/`mem_rdata` exactly `LATENCY` cycles after grant, in order, so the simulated DRAM presents realistic, deterministic timing. It also keeps saturating read and write access counters for bench statistics.

## Interface

Parameters:
- `AddrWidth`, default 64: request address width.
- `DataWidth`, default 512: data width; strobe width is `DataWidth/8`.
- `LATENCY`, default 4: cycles from grant to response; legal range 1..64.
- `MAX_OUTSTANDING`, default 8: maximum granted-but-unanswered requests; legal range 1..64.

Ports (clock and reset first):
- `clk_i`, in, 1: clock; all logic is on the rising edge.
- `rst_i`, in, 1: reset, synchronous and active-high.
- `mem_req_i`, in, 1: request from the translator.
- `mem_gnt_o`, out, 1: request accepted this cycle.
- `mem_addr_i`, in, AddrWidth: byte address.
- `mem_wdata_i`, in, DataWidth: write data.
- `mem_strb_i`, in, DataWidth/8: byte enables.
- `mem_we_i`, in, 1: 1 = write, 0 = read.
- `mem_rvalid_o`, out, 1: response valid, issued for both reads and writes.
- `mem_rdata_o`, out, DataWidth: read data; 0 for write responses.
- `bm_req_o`, out, 1: backing memory access.
- `bm_we_o`, out, 1: backing memory write enable.
- `bm_addr_o`, out, AddrWidth: backing memory address.
- `bm_wdata_o`, out, DataWidth: backing memory write data.
- `bm_strb_o`, out, DataWidth/8: backing memory byte enables.
- `bm_rdata_i`, in, DataWidth: backing memory read data, valid the cycle after `bm_req_o`.
- `rd_count_o`, out, 32: granted reads, saturating.
- `wr_count_o`, out, 32: granted writes, saturating.

## Operation

- **Outstanding counter `cnt`** (width `$clog2(MAX_OUTSTANDING+1)`):
  - increments on grant and decrements on `mem_rvalid_o`;
  - on a simultaneous grant and response, `cnt` is unchanged.
- **Grant rule:** `mem_gnt_o = mem_req_i && !rst_i && (cnt < MAX_OUTSTANDING || mem_rvalid_o)`. This is combinational; a retiring response frees its slot in the same cycle.
- **Backing memory forwarding:** `bm_req_o = mem_gnt_o`. `bm_we_o`, `bm_addr_o`, `bm_wdata_o` and `bm_strb_o` pass through combinationally from the `mem_*` inputs. When `bm_req_o` = 0, `bm_*` outputs are 0.
- **Response pipeline:** a valid/we tag pipe of depth `LATENCY` plus a data pipe of depth `LATENCY-1`.
  - Stage 1 is loaded at the grant edge.
  - In the cycle after grant, `bm_rdata_i` is captured into the data stage if the op was a read; a write captures 0.
  - `mem_rvalid_o` is the stage-`LATENCY` valid bit.
  - For `LATENCY` = 1, `mem_rdata_o` is `bm_rdata_i` (reads) or 0 (writes), combinationally.
- **Counters:** `rd_count_o` / `wr_count_o` increment on each read / write grant. At `32'hFFFF_FFFF` they hold.
- **Ordering:** responses are strictly in grant order with no reordering or dropping. A new grant every cycle is allowed when `MAX_OUTSTANDING >= LATENCY`.

## Timing

- **Reset values:** with `rst_i` high at an edge, all pipe stages, `cnt` and both counters clear to 0. `mem_rvalid_o` = 0, `mem_rdata_o` = 0, `mem_gnt_o` = 0 and `bm_req_o` = 0 while `rst_i` is high.
- **Latency:** a grant in cycle t gives `bm_req_o` in t, `bm_rdata_i` sampled at t+1, and `mem_rvalid_o` in t+LATENCY. Latency is independent of load.
- **Throughput:** one grant per cycle. Steady-state rate is `min(1, MAX_OUTSTANDING/LATENCY)`.
- **Full:** at `cnt == MAX_OUTSTANDING` with no response retiring, `mem_gnt_o` = 0. The request must be held by the translator; no state changes.
- **Empty:** at `cnt == 0`, `mem_rvalid_o` is 0 by construction. An underflow attempt (rvalid with `cnt == 0`) is an assertion failure.
- **Reset mid-operation:** all in-flight responses are discarded and never emitted. The first grant after reset responds LATENCY cycles later as normal.
- **Parameter checks:** an elaboration assertion fails for `LATENCY == 0` or `MAX_OUTSTANDING == 0`.

## Test plan

- LATENCY=4: single read granted at cycle 10 to addr 0x40, backing memory returns 0xA5 pattern → `mem_rvalid_o` only in cycle 14, data equals the pattern, `rd_count_o` = 1.
- LATENCY=4, MAX_OUTSTANDING=2: `mem_req_i` held high from cycle 0 → grants in 0, 1, 4, 5, 8…; rvalid in 4, 5, 8, 9; `cnt` never exceeds 2.
- LATENCY=1, MAX_OUTSTANDING=8: write (strb 0x0F, data 0x1234) then read of the same addr back-to-back → `bm_*` mirrors the inputs in the grant cycle; write response rdata = 0; read rvalid one cycle after its grant.
- LATENCY=6: 3 reads granted, then `rst_i` pulsed for one cycle before the first response → no `mem_rvalid_o` for 10 cycles; a fresh read responds exactly 6 cycles after its grant.
- `wr_count_o` preloaded to 0xFFFF_FFFE via force, then 3 writes → holds at 0xFFFF_FFFF.
- Random req/we/addr for 10k cycles against a reference queue model → every response is in order, data matches, latency is exact, and `cnt` returns to 0 at the end.
